// File: rtl/biu_arb_pkg.sv
// Shared types and helpers for the BIU round-robin arbiter.
package biu_arb_pkg;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT
   } arb_state_t;

   // Round-robin successor of ptr, wrapping at num_req.
   function automatic int unsigned rr_next(input int unsigned ptr, input int unsigned num_req);
      return (ptr + 32'd1 >= num_req) ? 32'd0 : ptr + 32'd1;
   endfunction

endpackage

// File: rtl/biu_arbiter_rr_priority_select.sv
// Combinational round-robin selector: first set request at or above ptr, with wrap.
module rr_priority_select
   import biu_arb_pkg::*;
#(
   parameter  int unsigned NUM_REQ = 4,
   localparam int unsigned IDX_W   = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   ptr,
   output logic [NUM_REQ-1:0] sel,
   output logic [IDX_W-1:0]   sel_idx,
   output logic               any
);

   localparam int unsigned DBL_W = 2 * NUM_REQ;

   logic [DBL_W-1:0] dbl;
   logic [DBL_W-1:0] mask;
   logic [DBL_W-1:0] masked;
   logic             found;

   // Upper copy of the request vector supplies the wrapped-around candidates.
   assign dbl    = {req, req};
   assign mask   = ~((DBL_W'(1) << ptr) - DBL_W'(1));
   assign masked = dbl & mask;

   always_comb begin
      found   = 1'b0;
      sel_idx = '0;
      sel     = '0;
      any     = |req;
      for (int unsigned i = 0; i < DBL_W; i++) begin
         if (!found && masked[i]) begin
            found   = 1'b1;
            sel_idx = IDX_W'(i % NUM_REQ);
         end
      end
      if (any) sel[sel_idx] = 1'b1;
   end

endmodule

// File: rtl/biu_arbiter.sv
// Round-robin arbiter sharing one BIU master port among NUM_REQ device-side requesters.
module biu_arbiter
   import biu_arb_pkg::*;
#(
   parameter int unsigned NUM_REQ    = 4,
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned DATA_WIDTH = 32
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_address,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_out,
   input  logic [NUM_REQ-1:0]            req_rnw,
   input  logic [NUM_REQ-1:0]            req_en,
   output logic [DATA_WIDTH-1:0]         req_data_in,
   output logic [NUM_REQ-1:0]            req_data_valid,
   output logic [NUM_REQ-1:0]            req_busy,
   output logic [NUM_REQ-1:0]            gnt,
   output logic [ADDR_WIDTH-1:0]         m_address,
   output logic [DATA_WIDTH-1:0]         m_data_out,
   output logic                          m_rnw,
   output logic                          m_en,
   input  logic [DATA_WIDTH-1:0]         m_data_in,
   input  logic                          m_data_valid,
   input  logic                          m_busy
);

   localparam int unsigned IDX_W = $clog2(NUM_REQ);

   arb_state_t             state;
   logic [IDX_W-1:0]       rr_ptr;
   logic [IDX_W-1:0]       gnt_idx;
   logic [NUM_REQ-1:0]     win_sel;
   logic [IDX_W-1:0]       win_idx;
   logic                   win_any;
   logic [ADDR_WIDTH-1:0]  win_addr;
   logic [DATA_WIDTH-1:0]  win_wdata;
   logic                   win_rnw;

   rr_priority_select #(.NUM_REQ(NUM_REQ)) u_sel (
      .req     (req_en),
      .ptr     (rr_ptr),
      .sel     (win_sel),
      .sel_idx (win_idx),
      .any     (win_any)
   );

   // Winner's request fields, one-hot muxed from the flattened requester vectors.
   always_comb begin
      win_addr  = '0;
      win_wdata = '0;
      win_rnw   = 1'b1;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         if (win_sel[i]) begin
            win_addr  = req_address[i*ADDR_WIDTH +: ADDR_WIDTH];
            win_wdata = req_data_out[i*DATA_WIDTH +: DATA_WIDTH];
            win_rnw   = req_rnw[i];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         rr_ptr     <= '0;
         gnt        <= '0;
         gnt_idx    <= '0;
         m_en       <= 1'b0;
         m_address  <= '0;
         m_data_out <= '0;
         m_rnw      <= 1'b1;
      end else begin
         case (state)
            IDLE: begin
               if (win_any) begin
                  state      <= ISSUE;
                  gnt        <= win_sel;
                  gnt_idx    <= win_idx;
                  m_address  <= win_addr;
                  m_data_out <= win_wdata;
                  m_rnw      <= win_rnw;
                  m_en       <= 1'b1;
               end
            end
            ISSUE: begin
               if (!m_busy) begin
                  state <= WAIT;
                  m_en  <= 1'b0;
               end
            end
            WAIT: begin
               // Pointer moves only on completion so a stalled owner keeps its turn.
               if (m_data_valid) begin
                  state  <= IDLE;
                  gnt    <= '0;
                  rr_ptr <= IDX_W'(rr_next(32'(gnt_idx), NUM_REQ));
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Zero-cycle return path; valid outside WAIT is dropped.
   assign req_data_valid = (state == WAIT && m_data_valid) ? gnt : '0;
   assign req_data_in    = m_data_in;
   assign req_busy       = {NUM_REQ{state != IDLE}};

endmodule

// File: tb/tb_biu_arbiter.sv
// Directed plus randomized bench for biu_arbiter against a transaction-level round-robin model.
module tb_biu_arbiter;

   localparam int unsigned N  = 4;
   localparam int unsigned AW = 32;
   localparam int unsigned DW = 32;

   logic            clk = 1'b0;
   logic            rst;
   logic [N*AW-1:0] req_address;
   logic [N*DW-1:0] req_data_out;
   logic [N-1:0]    req_rnw;
   logic [N-1:0]    req_en;
   logic [DW-1:0]   req_data_in;
   logic [N-1:0]    req_data_valid;
   logic [N-1:0]    req_busy;
   logic [N-1:0]    gnt;
   logic [AW-1:0]   m_address;
   logic [DW-1:0]   m_data_out;
   logic            m_rnw;
   logic            m_en;
   logic [DW-1:0]   m_data_in;
   logic            m_data_valid;
   logic            m_busy;

   int checks = 0;
   int errors = 0;
   int model_ptr = 0;

   logic [AW-1:0] addr_v [N];
   logic [DW-1:0] data_v [N];
   logic          rnw_v  [N];

   always #5 clk = ~clk;

   biu_arbiter #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
      .clk            (clk),
      .rst            (rst),
      .req_address    (req_address),
      .req_data_out   (req_data_out),
      .req_rnw        (req_rnw),
      .req_en         (req_en),
      .req_data_in    (req_data_in),
      .req_data_valid (req_data_valid),
      .req_busy       (req_busy),
      .gnt            (gnt),
      .m_address      (m_address),
      .m_data_out     (m_data_out),
      .m_rnw          (m_rnw),
      .m_en           (m_en),
      .m_data_in      (m_data_in),
      .m_data_valid   (m_data_valid),
      .m_busy         (m_busy)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic drive_reqs();
      for (int i = 0; i < int'(N); i++) begin
         req_address[i*AW +: AW]  = addr_v[i];
         req_data_out[i*DW +: DW] = data_v[i];
         req_rnw[i]               = rnw_v[i];
      end
   endtask

   task automatic scramble();
      for (int i = 0; i < int'(N); i++) begin
         addr_v[i] = $urandom;
         data_v[i] = $urandom;
         rnw_v[i]  = 1'($urandom);
      end
      drive_reqs();
   endtask

   // Reference: first pending requester at or after the pointer, wrapping.
   function automatic int pick(input logic [N-1:0] r, input int ptr);
      for (int k = 0; k < int'(N); k++)
         if (r[(ptr + k) % int'(N)]) return (ptr + k) % int'(N);
      return -1;
   endfunction

   function automatic logic [N-1:0] onehot(input int idx);
      logic [N-1:0] v;
      v = '0;
      v[idx] = 1'b1;
      return v;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // One complete transaction from IDLE: grant, busy_n stalled ISSUE cycles, lat idle WAIT cycles, completion.
   task automatic run_txn(input logic [N-1:0] reqs, input int busy_n, input int lat,
                          input logic [DW-1:0] rd, output int w);
      logic [AW-1:0] ea;
      logic [DW-1:0] ed;
      logic          er;
      req_en = reqs;
      drive_reqs();
      w  = pick(reqs, model_ptr);
      ea = addr_v[w];
      ed = data_v[w];
      er = rnw_v[w];
      step();
      chk("grant", 64'(gnt), 64'(onehot(w)));
      chk("issue_m_en", 64'(m_en), 64'd1);
      chk("issue_addr", 64'(m_address), 64'(ea));
      chk("issue_wdata", 64'(m_data_out), 64'(ed));
      chk("issue_rnw", 64'(m_rnw), 64'(er));
      chk("issue_busy", 64'(req_busy), 64'({N{1'b1}}));
      scramble();
      for (int b = 0; b < busy_n; b++) begin
         m_busy       = 1'b1;
         m_data_valid = 1'($urandom);
         #1;
         chk("spurious_issue", 64'(req_data_valid), 64'd0);
         step();
         chk("hold_m_en", 64'(m_en), 64'd1);
         chk("hold_addr", 64'(m_address), 64'(ea));
         chk("hold_wdata", 64'(m_data_out), 64'(ed));
      end
      m_busy       = 1'b0;
      m_data_valid = 1'b0;
      step();
      chk("wait_m_en", 64'(m_en), 64'd0);
      chk("wait_gnt", 64'(gnt), 64'(onehot(w)));
      chk("wait_wdata", 64'(m_data_out), 64'(ed));
      for (int l = 0; l < lat; l++) begin
         m_busy = 1'($urandom);
         chk("wait_no_valid", 64'(req_data_valid), 64'd0);
         chk("no_reissue", 64'(m_en), 64'd0);
         step();
      end
      m_busy       = 1'b0;
      m_data_in    = rd;
      m_data_valid = 1'b1;
      #1;
      chk("done_valid", 64'(req_data_valid), 64'(onehot(w)));
      chk("done_rdata", 64'(req_data_in), 64'(rd));
      step();
      m_data_valid = 1'b0;
      m_data_in    = $urandom;
      chk("idle_gnt", 64'(gnt), 64'd0);
      chk("idle_busy", 64'(req_busy), 64'd0);
      chk("idle_m_en", 64'(m_en), 64'd0);
      model_ptr = (w + 1) % int'(N);
   endtask

   initial begin
      int w;
      logic [N-1:0] r;

      rst = 1'b1;
      req_en = '0;
      m_data_in = '0;
      m_data_valid = 1'b0;
      m_busy = 1'b0;
      for (int i = 0; i < int'(N); i++) begin
         addr_v[i] = '0;
         data_v[i] = '0;
         rnw_v[i]  = 1'b1;
      end
      drive_reqs();
      step();
      step();
      chk("rst_gnt", 64'(gnt), 64'd0);
      chk("rst_m_en", 64'(m_en), 64'd0);
      chk("rst_addr", 64'(m_address), 64'd0);
      chk("rst_wdata", 64'(m_data_out), 64'd0);
      chk("rst_rnw", 64'(m_rnw), 64'd1);
      chk("rst_valid", 64'(req_data_valid), 64'd0);
      chk("rst_busy", 64'(req_busy), 64'd0);
      rst = 1'b0;
      step();

      // Single read from requester 2, valid three cycles after accept.
      scramble();
      addr_v[2] = 32'h0000_1000;
      rnw_v[2]  = 1'b1;
      run_txn(4'b0100, 0, 2, 32'hDEAD_BEEF, w);
      chk("single_winner", 64'(w), 64'd2);

      // Pointer now sits at 3: all-pending grant must go to 3 first.
      run_txn(4'b1111, 0, 0, $urandom, w);
      chk("ptr_after_single", 64'(w), 64'd3);

      // Round-robin with all requesters pending, immediate completion.
      for (int t = 0; t < 5; t++) begin
         run_txn(4'b1111, 0, 0, $urandom, w);
         chk("rr_order", 64'(w), 64'(t % 4));
      end

      // Backpressure: five stalled ISSUE cycles.
      run_txn(4'b1000, 5, 1, $urandom, w);
      chk("bp_winner", 64'(w), 64'd3);

      // Write from requester 1; bench scrambles its write data after grant.
      scramble();
      data_v[1] = 32'hA5A5_A5A5;
      rnw_v[1]  = 1'b0;
      run_txn(4'b0010, 1, 1, $urandom, w);
      chk("write_winner", 64'(w), 64'd1);

      // Spurious valid while IDLE.
      req_en = '0;
      m_data_valid = 1'b1;
      #1;
      chk("spurious_idle_valid", 64'(req_data_valid), 64'd0);
      step();
      m_data_valid = 1'b0;
      chk("spurious_idle_gnt", 64'(gnt), 64'd0);
      chk("spurious_idle_busy", 64'(req_busy), 64'd0);

      // Reset while in WAIT, then a late valid.
      req_en = 4'b0001;
      step();
      chk("rw_grant", 64'(gnt), 64'd1);
      step();
      chk("rw_in_wait", 64'(m_en), 64'd0);
      rst = 1'b1;
      req_en = '0;
      step();
      rst = 1'b0;
      chk("rw_gnt", 64'(gnt), 64'd0);
      chk("rw_m_en", 64'(m_en), 64'd0);
      chk("rw_addr", 64'(m_address), 64'd0);
      chk("rw_rnw", 64'(m_rnw), 64'd1);
      chk("rw_busy", 64'(req_busy), 64'd0);
      m_data_valid = 1'b1;
      #1;
      chk("rw_late_valid", 64'(req_data_valid), 64'd0);
      step();
      m_data_valid = 1'b0;
      chk("rw_stay_idle", 64'(req_busy), 64'd0);
      chk("rw_stay_gnt", 64'(gnt), 64'd0);
      model_ptr = 0;

      // Randomized traffic against the model.
      for (int t = 0; t < 24; t++) begin
         scramble();
         r = N'($urandom_range(1, (1 << N) - 1));
         run_txn(r, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), $urandom, w);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/biu_arbiter.md
# biu_arbiter

Shares a single BIU master port among `NUM_REQ` requesting devices using round-robin arbitration. Each requester uses the `biu_master_if` device-side signal set, flattened into vectors. The arbiter captures one request at a time, issues it to the BIU, waits for completion and routes the response back to the owner. It sits between the device-side clients (CPU fetch, DMA, debug) and the BIU `biu` modport.

## Interface
- `NUM_REQ`, 4: number of requesters, 2–8.
- `ADDR_WIDTH`, 32: address width.
- `DATA_WIDTH`, 32: data width.
- `IDX_W`, `$clog2(NUM_REQ)`: localparam, requester index width.

Ports:
- `clk` in 1: the only clock.
- `rst` in 1: synchronous, active-high reset.
- `req_address` in NUM_REQ*ADDR_WIDTH: requester i occupies slice [i*ADDR_WIDTH +: ADDR_WIDTH].
- `req_data_out` in NUM_REQ*DATA_WIDTH: write data, sliced the same way.
- `req_rnw` in NUM_REQ: 1 = read, 0 = write.
- `req_en` in NUM_REQ: request pending; held until the matching `req_data_valid`.
- `req_data_in` out DATA_WIDTH: read data, shared by all requesters; qualify with `req_data_valid[i]`.
- `req_data_valid` out NUM_REQ: one-hot completion pulse.
- `req_busy` out NUM_REQ: high while the arbiter is not in IDLE.
- `gnt` out NUM_REQ: one-hot owner of the current transaction; all zero in IDLE.
- `m_address` out ADDR_WIDTH: to BIU.
- `m_data_out` out DATA_WIDTH: to BIU.
- `m_rnw` out 1: to BIU.
- `m_en` out 1: to BIU.
- `m_data_in` in DATA_WIDTH: from BIU.
- `m_data_valid` in 1: from BIU.
- `m_busy` in 1: from BIU.

## Operation
BIU contract:
- A request is accepted on a cycle with `m_en`=1 and `m_busy`=0.
- Completion is a single-cycle `m_data_valid` pulse, for reads and writes alike.
- At most one transaction is outstanding.

State machine, state encoded as `arb_state_t`:
- **IDLE**
  - If any `req_en` is set, select the winner round-robin, starting at `rr_ptr` and searching upward with wrap.
  - Register `gnt`, and latch the winner's address, data and rnw into `m_*`.
  - Go to ISSUE. Otherwise stay in IDLE.
- **ISSUE**
  - Drive `m_en`=1 from the latched values.
  - When `m_busy`=0, the request is accepted: go to WAIT and drop `m_en`. Otherwise hold.
- **WAIT**
  - When `m_data_valid`=1, drive `req_data_valid[g]`=1 and `req_data_in`=`m_data_in` combinationally that same cycle.
  - Set `rr_ptr`=(g+1) mod NUM_REQ, clear `gnt` and return to IDLE.

Rules:
- Latched `m_*` values are immune to requester changes after the grant.
- A requester dropping `req_en` mid-transaction is illegal. The transaction completes regardless and `req_data_valid[g]` still pulses.
- `m_data_valid` in IDLE or ISSUE is a protocol error. It is ignored: no `req_data_valid` is produced.
- `rr_ptr` advances only on completion, never on grant.

Reset values:
- State IDLE, `rr_ptr`=0.
- `gnt`=0, `m_en`=0, `m_address`=0, `m_data_out`=0, `m_rnw`=1.
- `req_data_valid`=0, `req_busy`=0.

Reset mid-transaction abandons the transaction. A late `m_data_valid` after reset is dropped.

## Timing
- Request seen in IDLE at cycle 0: `gnt` and `m_en` are high at cycle 1.
- With `m_busy`=0, the request is accepted at cycle 1 and the arbiter is in WAIT at cycle 2.
- Completion at cycle k: `req_data_valid` pulses at cycle k (zero-cycle return path). IDLE at k+1; the next grant is visible at k+2.
- Minimum back-to-back spacing: 1 IDLE bubble per transaction.
- Fairness: a continuously pending requester is granted within NUM_REQ transactions.

## Structure
- `biu_arb_pkg` holds:
  - `typedef enum logic [1:0] {IDLE, ISSUE, WAIT} arb_state_t`.
  - Function `rr_next(ptr)`.
- Sub-module `rr_priority_select`, combinational:
  - Inputs: `req[NUM_REQ]`, `ptr[IDX_W]`.
  - Outputs: one-hot `sel`, index `sel_idx`, `any`.
  - Implemented as a double-width masked priority search.
- The top level holds the FSM, the latches and the response routing.

## Test plan
- **Single read.** `req_en`=4'b0100, addr 0x1000, `m_busy`=0, `m_data_valid` with 0xDEADBEEF 3 cycles after accept. Expect `gnt`=4'b0100 at cycle 1, `m_address`=0x1000, `req_data_valid`=4'b0100 with 0xDEADBEEF, then `rr_ptr`=3.
- **Round-robin.** All four `req_en` held high, each transaction completing immediately. Expect grants in order 0,1,2,3,0 and exactly one `req_data_valid` bit per completion.
- **Backpressure.** `m_busy`=1 for 5 cycles during ISSUE. Expect `m_en` held for all 5 cycles with address/data stable, acceptance on the 6th, and no duplicate issue.
- **Write.** Requester 1 issues rnw=0, data 0xA5A5A5A5 while requester 1 alters `req_data_out` after the grant. Expect `m_data_out` to stay 0xA5A5A5A5 and completion to be routed to bit 1.
- **Reset in WAIT.** Assert `rst` for 1 cycle, then send `m_data_valid`. Expect all outputs at reset values, `req_data_valid` to stay 0 and the FSM to remain in IDLE.
- **Spurious valid.** `m_data_valid`=1 in IDLE. Expect no `req_data_valid` and no state change.
